// File: rtl/fetch_unit.sv
// fetch_unit: program counter and instruction register stage of the VeriRISC
// core. It holds PC and IR, decodes the opcode field for the sequence
// controller, and drives the memory address mux. The mux selects PC during
// fetch and the IR operand during execute.
// Optional feature: define FETCH_UNIT_RETIRE_CNT_EN to add a 16-bit saturating
// count of retired instruction loads on output 'retired'.

package control_pkg;
  typedef enum logic [2:0] {
    HLT = 3'b000,
    SKZ = 3'b001,
    ADD = 3'b010,
    AND = 3'b011,
    XOR = 3'b100,
    LDA = 3'b101,
    STO = 3'b110,
    JMP = 3'b111
  } opcode_t;
endpackage

module fetch_unit #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DWIDTH-1:0]    mem_data,
  input  logic                 fetch,
  input  logic                 load_ir,
  input  logic                 inc_pc,
  input  logic                 load_pc,
  input  logic                 halt,
  output control_pkg::opcode_t opcode,
  output logic [AWIDTH-1:0]    ir_addr,
  output logic [AWIDTH-1:0]    pc,
  output logic [AWIDTH-1:0]    addr,
  output logic                 halted
`ifdef FETCH_UNIT_RETIRE_CNT_EN
  ,
  output logic [15:0]          retired
`endif
);

  // The opcode field is fixed at three bits, so the word must be opcode plus operand.
  if (DWIDTH != AWIDTH + 3) begin : g_bad_width
    $error("fetch_unit: DWIDTH must equal AWIDTH + 3");
  end

  logic [DWIDTH-1:0] ir;
  logic [AWIDTH-1:0] pc_q;
  logic              halted_q;

  // PC update. A jump load takes priority over increment, and the increment
  // wraps silently. The load uses the IR value from before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else if (!halted_q) begin
      if (load_pc) begin
        pc_q <= ir[AWIDTH-1:0];
      end else if (inc_pc) begin
        pc_q <= pc_q + AWIDTH'(1);
      end
    end
  end

  // IR capture from memory. It is frozen once the core has halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir <= '0;
    end else if (!halted_q && load_ir) begin
      ir <= mem_data;
    end
  end

  // Sticky halt flag. Only reset clears it. Because it is registered, strobes
  // on the same edge as the halt request still take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (halt) begin
      halted_q <= 1'b1;
    end
  end

`ifdef FETCH_UNIT_RETIRE_CNT_EN
  logic [15:0] retired_cnt;

  // Count of accepted instruction loads. It saturates at all-ones and holds while halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (!halted_q && load_ir && (retired_cnt != 16'hFFFF)) begin
      retired_cnt <= retired_cnt + 16'd1;
    end
  end

  assign retired = retired_cnt;
`endif

  // Decode is a plain slice of the IR. Every encoding is a legal opcode.
  assign opcode  = control_pkg::opcode_t'(ir[DWIDTH-1:AWIDTH]);
  assign ir_addr = ir[AWIDTH-1:0];
  assign pc      = pc_q;
  assign halted  = halted_q;

  // The address mux is combinational so memory sees the new address in the same cycle.
  always_comb begin
    addr = fetch ? pc_q : ir[AWIDTH-1:0];
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. Directed steps feed a reference model.
// Predicted state is queued when each step is driven and compared after the clock edge.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic                 clk;
  logic                 rst;
  logic [7:0]           mem_data;
  logic                 fetch;
  logic                 load_ir;
  logic                 inc_pc;
  logic                 load_pc;
  logic                 halt;
  control_pkg::opcode_t opcode;
  logic [4:0]           ir_addr;
  logic [4:0]           pc;
  logic [4:0]           addr;
  logic                 halted;
`ifdef FETCH_UNIT_RETIRE_CNT_EN
  logic [15:0]          retired;
`endif

  int checks = 0;
  int passed = 0;
  int failed = 0;

  typedef struct {
    string       tag;
    logic [4:0]  pc;
    logic [7:0]  ir;
    logic        halted;
    logic [15:0] ret;
  } exp_t;

  exp_t sb[$];

  logic [4:0]  m_pc;
  logic [7:0]  m_ir;
  logic        m_halted;
  logic [15:0] m_ret;

  fetch_unit #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_data (mem_data),
    .fetch    (fetch),
    .load_ir  (load_ir),
    .inc_pc   (inc_pc),
    .load_pc  (load_pc),
    .halt     (halt),
    .opcode   (opcode),
    .ir_addr  (ir_addr),
    .pc       (pc),
    .addr     (addr),
    .halted   (halted)
`ifdef FETCH_UNIT_RETIRE_CNT_EN
    ,
    .retired  (retired)
`endif
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    m_pc     = '0;
    m_ir     = '0;
    m_halted = 1'b0;
    m_ret    = '0;
  endtask

  task automatic scoreboardCheck();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failed++;
      $error("[TB] FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      checkOutput({e.tag, ".pc"},      16'(pc),      16'(e.pc));
      checkOutput({e.tag, ".ir_addr"}, 16'(ir_addr), 16'(e.ir[4:0]));
      checkOutput({e.tag, ".opcode"},  16'(opcode),  16'(e.ir[7:5]));
      checkOutput({e.tag, ".halted"},  16'(halted),  16'(e.halted));
      checkOutput({e.tag, ".addr"},    16'(addr),    16'(fetch ? e.pc : e.ir[4:0]));
`ifdef FETCH_UNIT_RETIRE_CNT_EN
      checkOutput({e.tag, ".retired"}, retired,      e.ret);
`endif
    end
  endtask

  // One clock step: drive the strobes, predict the next state, queue the prediction, then compare after the edge.
  task automatic applyStimulus(input string tag, input logic [7:0] md,
                               input logic lir, input logic inc,
                               input logic lpc, input logic hlt);
    exp_t e;
    mem_data = md;
    load_ir  = lir;
    inc_pc   = inc;
    load_pc  = lpc;
    halt     = hlt;
    if (!m_halted) begin
      if (lpc)      m_pc = m_ir[4:0];
      else if (inc) m_pc = m_pc + 5'd1;
      if (lir) begin
        m_ir = md;
        if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
      end
    end
    if (hlt) m_halted = 1'b1;
    e.tag    = tag;
    e.pc     = m_pc;
    e.ir     = m_ir;
    e.halted = m_halted;
    e.ret    = m_ret;
    sb.push_back(e);
    @(posedge clk);
    #1;
    load_ir = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    halt    = 1'b0;
    scoreboardCheck();
  endtask

  task automatic applyReset(input string tag);
    rst = 1'b1;
    #2;
    resetModel();
    sb.delete();
    checkOutput({tag, ".pc"},     16'(pc),     16'h0);
    checkOutput({tag, ".opcode"}, 16'(opcode), 16'(control_pkg::HLT));
    checkOutput({tag, ".ir"},     16'(ir_addr), 16'h0);
    checkOutput({tag, ".halted"}, 16'(halted), 16'h0);
    checkOutput({tag, ".addr"},   16'(addr),   16'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    rst = 1'b1; mem_data = '0; fetch = 1'b1;
    load_ir = 1'b0; inc_pc = 1'b0; load_pc = 1'b0; halt = 1'b0;
    resetModel();
    applyReset("reset0");

    // Reach pc=7, ir=A3, then assert reset mid-cycle.
    applyStimulus("ld07", 8'h07, 1, 0, 0, 0);
    applyStimulus("ldA3_jmp7", 8'hA3, 1, 0, 1, 0);
    checkOutput("pre_rst.pc", 16'(pc), 16'd7);
    checkOutput("pre_rst.opcode", 16'(opcode), 16'd5);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_rst.pc",     16'(pc),      16'd0);
    checkOutput("async_rst.irad",   16'(ir_addr), 16'd0);
    checkOutput("async_rst.opcode", 16'(opcode),  16'(control_pkg::HLT));
    checkOutput("async_rst.halted", 16'(halted),  16'd0);
    resetModel();
    @(negedge clk);
    rst = 1'b0;

    // Fetch and increment.
    applyStimulus("ldA5", 8'hA5, 1, 0, 0, 0);
    checkOutput("ldA5.opcode", 16'(opcode), 16'b101);
    checkOutput("ldA5.ir_addr", 16'(ir_addr), 16'd5);
    for (int i = 0; i < 3; i++) applyStimulus("inc", 8'h00, 0, 1, 0, 0);
    applyStimulus("inc3to4", 8'h00, 0, 1, 0, 0);
    checkOutput("inc3to4.pc", 16'(pc), 16'd4);
    fetch = 1'b1; #1;
    checkOutput("addr_fetch", 16'(addr), 16'd4);
    fetch = 1'b0; #1;
    checkOutput("addr_exec", 16'(addr), 16'd5);
    fetch = 1'b1;

    // Wrap from 31 to 0.
    applyStimulus("ld1F", 8'h1F, 1, 0, 0, 0);
    applyStimulus("jmp31", 8'h00, 0, 0, 1, 0);
    checkOutput("jmp31.pc", 16'(pc), 16'd31);
    applyStimulus("wrap", 8'h00, 0, 1, 0, 0);
    checkOutput("wrap.pc", 16'(pc), 16'd0);

    // load_pc takes priority over inc_pc.
    applyStimulus("ld09", 8'h09, 1, 0, 0, 0);
    applyStimulus("prio", 8'h00, 0, 1, 1, 0);
    checkOutput("prio.pc", 16'(pc), 16'd9);

    // load_ir and load_pc on the same edge.
    applyStimulus("ld0C", 8'h0C, 1, 0, 0, 0);
    fetch = 1'b0;
    applyStimulus("simul", 8'hE3, 1, 0, 1, 0);
    checkOutput("simul.pc", 16'(pc), 16'd12);
    checkOutput("simul.ir_addr", 16'(ir_addr), 16'd3);
    fetch = 1'b1;

    // A strobe on the halt edge still applies. After that the core stays frozen.
    applyStimulus("halt_inc", 8'h00, 0, 1, 0, 1);
    checkOutput("halt_inc.pc", 16'(pc), 16'd13);
    for (int i = 0; i < 4; i++) applyStimulus("frozen", 8'hFF, 1, 1, 1, 1'(i % 2));
    checkOutput("frozen.pc", 16'(pc), 16'd13);
    checkOutput("frozen.ir_addr", 16'(ir_addr), 16'd3);
    checkOutput("frozen.halted", 16'(halted), 16'd1);
    applyReset("reset_halt");

`ifdef FETCH_UNIT_RETIRE_CNT_EN
    for (int i = 0; i < 3; i++) applyStimulus("retire", 8'h21, 1, 0, 0, 0);
    checkOutput("retire3", retired, 16'd3);
    force dut.retired_cnt = 16'hFFFE;
    #1;
    release dut.retired_cnt;
    m_ret = 16'hFFFE;
    for (int i = 0; i < 3; i++) applyStimulus("retire_sat", 8'h22, 1, 0, 0, 0);
    checkOutput("retire_sat.final", retired, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
